// File: rtl/execute_alu_issue_queue.sv
// Four-entry age-ordered ALU issue queue with writeback wakeup.
// Slot 0 is the oldest entry. The oldest ready entry issues into the registered o_* stage.
module execute_alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_enq_valid,
  output logic        o_enq_ready,
  input  logic        i_enq_src0_ready,
  input  logic        i_enq_src1_ready,
  input  logic [31:0] i_enq_src0_value,
  input  logic [31:0] i_enq_src1_value,
  input  logic [3:0]  i_enq_src0_rob,
  input  logic [3:0]  i_enq_src1_rob,
  input  logic [3:0]  i_enq_dst_rob,
  input  logic [25:0] i_enq_imm,
  input  logic [7:0]  i_enq_fid,
  input  logic [1:0]  i_enq_alu_math_imm,
  input  logic [2:0]  i_enq_alu_math_func,
  input  logic        i_enq_alu_shift_sa_sel,
  input  logic [1:0]  i_enq_alu_shift_func,
  input  logic [1:0]  i_enq_alu_mux,
  input  logic        i_wb_valid,
  input  logic [3:0]  i_wb_rob,
  input  logic [31:0] i_wb_value,
  output logic        o_valid,
  output logic [31:0] o_src0_value,
  output logic [31:0] o_src1_value,
  output logic [3:0]  o_dst_rob,
  output logic [25:0] o_imm,
  output logic [7:0]  o_fid,
  output logic [1:0]  o_alu_math_imm,
  output logic [2:0]  o_alu_math_func,
  output logic        o_alu_shift_sa_sel,
  output logic [1:0]  o_alu_shift_func,
  output logic [1:0]  o_alu_mux,
  output logic [2:0]  o_count
);

  typedef struct packed {
    logic        valid;
    logic        src0_ready;
    logic [31:0] src0_value;
    logic [3:0]  src0_rob;
    logic        src1_ready;
    logic [31:0] src1_value;
    logic [3:0]  src1_rob;
    logic [3:0]  dst_rob;
    logic [25:0] imm;
    logic [7:0]  fid;
    logic [1:0]  alu_math_imm;
    logic [2:0]  alu_math_func;
    logic        alu_shift_sa_sel;
    logic [1:0]  alu_shift_func;
    logic [1:0]  alu_mux;
  } entry_t;

  entry_t      q        [DEPTH];
  entry_t      q_next   [DEPTH];
  entry_t      woke_ext [DEPTH+1];
  entry_t      enq_entry;
  logic [2:0]  count, count_next;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  enq_slot;
  logic        enq_accept;

  function automatic entry_t wake(input entry_t e, input logic wb_valid,
                                  input logic [3:0] wb_rob, input logic [31:0] wb_value);
    entry_t r;
    r = e;
    if (wb_valid && !e.src0_ready && e.src0_rob == wb_rob) begin
      r.src0_ready = 1'b1;
      r.src0_value = wb_value;
    end
    if (wb_valid && !e.src1_ready && e.src1_rob == wb_rob) begin
      r.src1_ready = 1'b1;
      r.src1_value = wb_value;
    end
    return r;
  endfunction

  assign o_enq_ready = (count < 3'(DEPTH));
  assign o_count     = count;
  assign enq_accept  = i_enq_valid && o_enq_ready;

  // Select looks only at registered state; same-cycle wakeups become eligible next cycle.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (q[i].valid && q[i].src0_ready && q[i].src1_ready) begin
        win_valid = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    enq_entry = '{
      valid:            1'b1,
      src0_ready:       i_enq_src0_ready,
      src0_value:       i_enq_src0_value,
      src0_rob:         i_enq_src0_rob,
      src1_ready:       i_enq_src1_ready,
      src1_value:       i_enq_src1_value,
      src1_rob:         i_enq_src1_rob,
      dst_rob:          i_enq_dst_rob,
      imm:              i_enq_imm,
      fid:              i_enq_fid,
      alu_math_imm:     i_enq_alu_math_imm,
      alu_math_func:    i_enq_alu_math_func,
      alu_shift_sa_sel: i_enq_alu_shift_sa_sel,
      alu_shift_func:   i_enq_alu_shift_func,
      alu_mux:          i_enq_alu_mux
    };
    enq_entry = wake(enq_entry, i_wb_valid, i_wb_rob, i_wb_value);

    woke_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++)
      woke_ext[i] = wake(q[i], i_wb_valid, i_wb_rob, i_wb_value);

    // Entries above the winner slide down one slot, carrying their wakeups with them.
    for (int i = 0; i < DEPTH; i++) begin
      if (win_valid && i >= int'(win_idx)) q_next[i] = woke_ext[i+1];
      else                                 q_next[i] = woke_ext[i];
    end

    enq_slot = count[1:0] - {1'b0, win_valid};
    if (enq_accept) q_next[enq_slot] = enq_entry;

    count_next = count + {2'b0, enq_accept} - {2'b0, win_valid};
  end

  // NOTE: the entry array is a handful of flops, not a RAM, so it is cleared on reset
  // along with everything else; this keeps the first issued fields deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count              <= '0;
      o_valid            <= 1'b0;
      o_src0_value       <= '0;
      o_src1_value       <= '0;
      o_dst_rob          <= '0;
      o_imm              <= '0;
      o_fid              <= '0;
      o_alu_math_imm     <= '0;
      o_alu_math_func    <= '0;
      o_alu_shift_sa_sel <= 1'b0;
      o_alu_shift_func   <= '0;
      o_alu_mux          <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      count   <= '0;
      o_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_next[i];
      count   <= count_next;
      o_valid <= win_valid;
      if (win_valid) begin
        o_src0_value       <= q[win_idx].src0_value;
        o_src1_value       <= q[win_idx].src1_value;
        o_dst_rob          <= q[win_idx].dst_rob;
        o_imm              <= q[win_idx].imm;
        o_fid              <= q[win_idx].fid;
        o_alu_math_imm     <= q[win_idx].alu_math_imm;
        o_alu_math_func    <= q[win_idx].alu_math_func;
        o_alu_shift_sa_sel <= q[win_idx].alu_shift_sa_sel;
        o_alu_shift_func   <= q[win_idx].alu_shift_func;
        o_alu_mux          <= q[win_idx].alu_mux;
      end
    end
  end

endmodule

// File: tb/tb_execute_alu_issue_queue.sv
// Randomized and directed bench for execute_alu_issue_queue against a queue-based model.
module tb_execute_alu_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_flush;
  logic        i_enq_valid;
  logic        o_enq_ready;
  logic        i_enq_src0_ready, i_enq_src1_ready;
  logic [31:0] i_enq_src0_value, i_enq_src1_value;
  logic [3:0]  i_enq_src0_rob, i_enq_src1_rob, i_enq_dst_rob;
  logic [25:0] i_enq_imm;
  logic [7:0]  i_enq_fid;
  logic [1:0]  i_enq_alu_math_imm;
  logic [2:0]  i_enq_alu_math_func;
  logic        i_enq_alu_shift_sa_sel;
  logic [1:0]  i_enq_alu_shift_func;
  logic [1:0]  i_enq_alu_mux;
  logic        i_wb_valid;
  logic [3:0]  i_wb_rob;
  logic [31:0] i_wb_value;
  logic        o_valid;
  logic [31:0] o_src0_value, o_src1_value;
  logic [3:0]  o_dst_rob;
  logic [25:0] o_imm;
  logic [7:0]  o_fid;
  logic [1:0]  o_alu_math_imm;
  logic [2:0]  o_alu_math_func;
  logic        o_alu_shift_sa_sel;
  logic [1:0]  o_alu_shift_func;
  logic [1:0]  o_alu_mux;
  logic [2:0]  o_count;

  execute_alu_issue_queue dut (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
    .i_enq_src0_ready(i_enq_src0_ready), .i_enq_src1_ready(i_enq_src1_ready),
    .i_enq_src0_value(i_enq_src0_value), .i_enq_src1_value(i_enq_src1_value),
    .i_enq_src0_rob(i_enq_src0_rob), .i_enq_src1_rob(i_enq_src1_rob),
    .i_enq_dst_rob(i_enq_dst_rob), .i_enq_imm(i_enq_imm), .i_enq_fid(i_enq_fid),
    .i_enq_alu_math_imm(i_enq_alu_math_imm), .i_enq_alu_math_func(i_enq_alu_math_func),
    .i_enq_alu_shift_sa_sel(i_enq_alu_shift_sa_sel), .i_enq_alu_shift_func(i_enq_alu_shift_func),
    .i_enq_alu_mux(i_enq_alu_mux),
    .i_wb_valid(i_wb_valid), .i_wb_rob(i_wb_rob), .i_wb_value(i_wb_value),
    .o_valid(o_valid), .o_src0_value(o_src0_value), .o_src1_value(o_src1_value),
    .o_dst_rob(o_dst_rob), .o_imm(o_imm), .o_fid(o_fid),
    .o_alu_math_imm(o_alu_math_imm), .o_alu_math_func(o_alu_math_func),
    .o_alu_shift_sa_sel(o_alu_shift_sa_sel), .o_alu_shift_func(o_alu_shift_func),
    .o_alu_mux(o_alu_mux), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r0;
    logic [31:0] v0;
    logic [3:0]  t0;
    bit          r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic [47:0] pay;
  } m_ent_t;

  m_ent_t       mq[$];
  bit           exp_valid;
  logic [111:0] exp_data;
  int           n_vec  = 0;
  int           n_miss = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] enq_pay();
    return {i_enq_dst_rob, i_enq_imm, i_enq_fid, i_enq_alu_math_imm, i_enq_alu_math_func,
            i_enq_alu_shift_sa_sel, i_enq_alu_shift_func, i_enq_alu_mux};
  endfunction

  function automatic logic [111:0] out_data();
    return {o_src0_value, o_src1_value, o_dst_rob, o_imm, o_fid, o_alu_math_imm,
            o_alu_math_func, o_alu_shift_sa_sel, o_alu_shift_func, o_alu_mux};
  endfunction

  function automatic m_ent_t wake(input m_ent_t e);
    m_ent_t r = e;
    if (i_wb_valid && !r.r0 && r.t0 == i_wb_rob) begin r.r0 = 1; r.v0 = i_wb_value; end
    if (i_wb_valid && !r.r1 && r.t1 == i_wb_rob) begin r.r1 = 1; r.v1 = i_wb_value; end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_valid = 0;
    exp_data  = '0;
  endtask

  // One clock of the reference behaviour, evaluated from the inputs currently driven.
  task automatic model_step();
    int     win;
    bit     acc;
    m_ent_t e;
    if (i_flush) begin
      mq.delete();
      exp_valid = 0;
      return;
    end
    win = -1;
    for (int k = 0; k < mq.size(); k++)
      if (win < 0 && mq[k].r0 && mq[k].r1) win = k;
    acc = i_enq_valid && (mq.size() < 4);
    if (win >= 0) begin
      exp_data  = {mq[win].v0, mq[win].v1, mq[win].pay};
      exp_valid = 1;
      mq.delete(win);
    end else begin
      exp_valid = 0;
    end
    foreach (mq[k]) mq[k] = wake(mq[k]);
    if (acc) begin
      e = '{r0: i_enq_src0_ready, v0: i_enq_src0_value, t0: i_enq_src0_rob,
            r1: i_enq_src1_ready, v1: i_enq_src1_value, t1: i_enq_src1_rob, pay: enq_pay()};
      mq.push_back(wake(e));
    end
  endtask

  task automatic compare();
    check("valid", 128'(o_valid), 128'(exp_valid));
    check("count", 128'(o_count), 128'(mq.size()));
    check("enq_ready", 128'(o_enq_ready), 128'(mq.size() < 4));
    check("data", 128'(out_data()), 128'(exp_data));
  endtask

  task automatic set_enq(input bit v, input bit r0, input logic [31:0] v0, input logic [3:0] t0,
                         input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                         input logic [3:0] dst);
    i_enq_valid            = v;
    i_enq_src0_ready       = r0;
    i_enq_src0_value       = v0;
    i_enq_src0_rob         = t0;
    i_enq_src1_ready       = r1;
    i_enq_src1_value       = v1;
    i_enq_src1_rob         = t1;
    i_enq_dst_rob          = dst;
    i_enq_imm              = 26'($urandom);
    i_enq_fid              = 8'($urandom);
    i_enq_alu_math_imm     = 2'($urandom);
    i_enq_alu_math_func    = 3'($urandom);
    i_enq_alu_shift_sa_sel = 1'($urandom);
    i_enq_alu_shift_func   = 2'($urandom);
    i_enq_alu_mux          = 2'($urandom);
  endtask

  task automatic set_wb(input bit v, input logic [3:0] rob, input logic [31:0] val);
    i_wb_valid = v;
    i_wb_rob   = rob;
    i_wb_value = val;
  endtask

  task automatic idle();
    set_enq(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    i_flush = 0;
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    reset = 0;
    @(negedge clk);
    compare();

    // Single ready op into an empty queue.
    set_enq(1, 1, 32'h5, 0, 1, 32'h3, 0, 4'd2);
    step();
    check("single_wait_valid", 128'(o_valid), 128'(0));
    idle();
    step();
    check("single_valid", 128'(o_valid), 128'(1));
    check("single_src0", 128'(o_src0_value), 128'(32'h5));
    check("single_src1", 128'(o_src1_value), 128'(32'h3));
    check("single_dst", 128'(o_dst_rob), 128'(4'd2));
    step();
    check("single_drop", 128'(o_valid), 128'(0));
    check("single_count", 128'(o_count), 128'(0));

    // Younger ready op bypasses an older waiting one.
    set_enq(1, 1, 32'h10, 0, 0, 0, 4'd7, 4'd5);
    step();
    set_enq(1, 1, 32'h20, 0, 1, 32'h21, 0, 4'd6);
    step();
    idle();
    step();
    check("order_b_dst", 128'(o_dst_rob), 128'(4'd6));
    set_wb(1, 4'd7, 32'hDEADBEEF);
    step();
    check("order_a_not_yet", 128'(o_valid), 128'(0));
    idle();
    step();
    check("order_a_valid", 128'(o_valid), 128'(1));
    check("order_a_src1", 128'(o_src1_value), 128'(32'hDEADBEEF));

    // Enqueue catches a same-cycle writeback.
    set_enq(1, 0, 0, 4'd4, 1, 32'h22, 0, 4'd8);
    set_wb(1, 4'd4, 32'h11);
    step();
    idle();
    step();
    check("samecyc_valid", 128'(o_valid), 128'(1));
    check("samecyc_src0", 128'(o_src0_value), 128'(32'h11));

    // Fill with four waiters, reject a fifth, then drain in order.
    for (int k = 0; k < 4; k++) begin
      set_enq(1, 0, 0, 4'd9, 1, 32'(k), 0, 4'(k));
      step();
    end
    check("full_count", 128'(o_count), 128'(4));
    check("full_ready", 128'(o_enq_ready), 128'(0));
    set_enq(1, 1, 1, 0, 1, 1, 0, 4'd15);
    step();
    set_enq(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 4'd9, 32'h99);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain_dst", 128'(o_dst_rob), 128'(k));
      check("drain_valid", 128'(o_valid), 128'(1));
    end
    step();
    check("drain_done", 128'(o_valid), 128'(0));

    // Flush with a simultaneous enqueue; stale tags must not wake anything.
    for (int k = 0; k < 3; k++) begin
      set_enq(1, 0, 0, 4'd10, 1, 0, 0, 4'(k));
      step();
    end
    set_enq(1, 1, 1, 0, 1, 2, 0, 4'd3);
    i_flush = 1;
    step();
    check("flush_count", 128'(o_count), 128'(0));
    check("flush_valid", 128'(o_valid), 128'(0));
    idle();
    set_wb(1, 4'd10, 32'hAA);
    step();
    idle();
    step();
    check("flush_stale", 128'(o_valid), 128'(0));

    // Random traffic with a narrow tag space so wakeups collide often.
    for (int n = 0; n < 2000; n++) begin
      set_enq($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom,
              4'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom,
              4'($urandom_range(0, 3)), 4'($urandom));
      set_wb($urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom);
      i_flush = ($urandom_range(0, 99) < 3);
      step();
    end
    idle();
    i_flush = 1;
    step();
    idle();

    // Async reset between edges with two entries queued and an op just issued.
    set_enq(1, 0, 0, 4'd12, 1, 0, 0, 4'd1);
    step();
    set_enq(1, 0, 0, 4'd12, 1, 0, 0, 4'd2);
    step();
    set_enq(1, 1, 32'h77, 0, 1, 32'h78, 0, 4'd3);
    step();
    idle();
    step();
    check("pre_rst_valid", 128'(o_valid), 128'(1));
    check("pre_rst_count", 128'(o_count), 128'(2));
    #1 reset = 1;
    model_reset();
    #1;
    compare();
    @(negedge clk);
    reset = 0;
    set_wb(1, 4'd12, 32'h5);
    step();
    idle();
    step();
    check("post_rst_quiet", 128'(o_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/execute_alu_issue_queue.md
# execute_alu_issue_queue

Four-entry, age-ordered issue queue feeding the ALU execute pipeline. It accepts ALU micro-ops from dispatch, holds operands that are still waiting, and captures them from the writeback broadcast bus. Each cycle it issues the oldest entry with both operands ready into the ALU input register stage. It is the only producer of that stage's inputs and replaces direct dispatch-to-ALU wiring.

## Interface
- DEPTH, 4, number of entries; fixed at 4, other values unsupported
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_flush  in  1  synchronous pipeline flush; drops all entries
- i_enq_valid  in  1  dispatch presents a micro-op
- o_enq_ready  out  1  queue not full; enqueue accepted when i_enq_valid & o_enq_ready
- i_enq_src0_ready / i_enq_src1_ready  in  1 each  operand value already valid
- i_enq_src0_value / i_enq_src1_value  in  32 each  operand value (ignored if not ready)
- i_enq_src0_rob / i_enq_src1_rob  in  4 each  producer ROB tag (used if not ready)
- i_enq_dst_rob  in  4  destination ROB tag
- i_enq_imm  in  26;  i_enq_fid  in  8
- i_enq_alu_math_imm  in  2;  i_enq_alu_math_func  in  3;  i_enq_alu_shift_sa_sel  in  1;  i_enq_alu_shift_func  in  2;  i_enq_alu_mux  in  2
- i_wb_valid  in  1;  i_wb_rob  in  4;  i_wb_value  in  32  writeback broadcast
- o_valid  out  1  issued op valid this cycle (registered)
- o_src0_value, o_src1_value  out  32 each;  o_dst_rob  out  4;  o_imm  out  26;  o_fid  out  8
- o_alu_math_imm  out  2;  o_alu_math_func  out  3;  o_alu_shift_sa_sel  out  1;  o_alu_shift_func  out  2;  o_alu_mux  out  2
- o_count  out  3  occupied entries, 0..4

## Operation
- Compacting queue: slot 0 is the oldest. Valid entries are always contiguous from slot 0.
- Per-entry state: valid, srcN_ready, srcN_value, srcN_rob, plus all payload fields.
- Wakeup, every cycle: for each valid entry and operand with ready=0, if i_wb_valid and srcN_rob == i_wb_rob, then value <= i_wb_value and ready <= 1.
- Enqueue wakeup: if an enqueued operand is not ready and its tag matches the same-cycle wb, it is written as ready with i_wb_value.
- Select: combinational from registered state only. The lowest-index valid entry with src0_ready & src1_ready wins.
  - Same-cycle wakeups do not affect select; a woken entry is eligible the next cycle.
- Issue:
  - The winner's fields are registered into the o_* outputs and o_valid <= 1.
  - The winner is removed; younger entries shift down one slot; their same-cycle wakeups apply to the shifted copy.
  - If there is no winner, o_valid <= 0 and the o_* data fields hold their previous values.
- Enqueue: the new entry is written to slot (count − issued), i.e. after compaction.
- o_enq_ready = (count < 4), computed from registered count. When full, no enqueue is accepted, even in a cycle that issues.
- count_next = count + enq_accepted − issued.
- No downstream backpressure: the ALU stage always accepts.
- Flush (i_flush=1):
  - Next edge: all entries invalid, count=0, o_valid=0.
  - Any enqueue and issue that cycle are discarded.
  - Flush has priority over all other updates.

## Timing
- Reset values: o_valid=0, o_count=0, o_enq_ready=1 (combinational from count), all entries invalid, o_* data fields 0.
- Reset is asynchronous, so assertion mid-operation clears state immediately, with no dependence on clk.
- Enqueue with both operands ready, accepted at edge E0, into an empty queue: selected during cycle E0→E1; o_valid=1 after edge E1.
- Operand woken at edge W (entry already queued): selected in cycle W→W+1; o_valid after edge W+1.
- Throughput: one issue per cycle. Sustained enqueue of one ready op per cycle gives back-to-back o_valid.
- o_valid is high for exactly one cycle per issued op.

## Test plan
- Reset then single enqueue: src0=0x00000005, src1=0x00000003, both ready, dst_rob=2 at edge 0 → o_valid=1 after edge 1 with values 5/3, dst_rob=2; o_valid=0 after edge 2; o_count returns to 0.
- Wakeup ordering: enqueue A (src1 waits on rob 7), then B (ready). → B issues first. Then wb rob=7, value=0xDEADBEEF → A issues one cycle later with o_src1_value=0xDEADBEEF.
- Same-cycle enqueue/wb match: enqueue with src0 waiting on rob 4 while wb rob=4, value=0x11 → entry captured ready and issues next cycle with src0=0x11.
- Full: enqueue 4 ops all waiting on rob 9 → o_enq_ready=0 and o_count=4; a 5th i_enq_valid is not accepted. wb rob 9 → ops issue in enqueue order over 4 consecutive cycles.
- Flush: 3 entries queued plus a simultaneous enqueue and i_flush → next cycle o_count=0, o_valid=0; a later wb matching the old tags causes no issue.
- Async reset mid-stream: assert reset between edges with 2 entries and o_valid=1 → o_valid and o_count are 0 immediately, before the next edge.
